// File: rtl/ni_pkg.sv
// Shared helpers for the AI-Grid GPU network interface: GPU ID <-> routing
// address arithmetic, ID legality and header placement.
package ni_pkg;

  typedef struct packed {
    logic push;
    logic drop;
  } ni_verdict_t;

  // LSB position of the header field inside a flit.
  function automatic int unsigned hdr_lsb(input int unsigned data_w, input int unsigned id_w);
    return data_w - id_w;
  endfunction

  function automatic int unsigned gpu_id_to_addr(input int unsigned id, input int unsigned leaf_w);
    return id + (32'd1 << leaf_w) - 32'd1;
  endfunction

  function automatic int unsigned addr_to_gpu_id(input int unsigned addr, input int unsigned leaf_w);
    return addr - ((32'd1 << leaf_w) - 32'd1);
  endfunction

  function automatic logic id_legal(input int unsigned id, input int unsigned max_gpu);
    return (id >= 32'd1) && (id <= max_gpu);
  endfunction

  // An accepted flit is either pushed or dropped, never both.
  function automatic ni_verdict_t classify(input logic accept, input logic ok);
    ni_verdict_t v;
    v.push = accept && ok;
    v.drop = accept && !ok;
    return v;
  endfunction

endpackage

// File: rtl/ni_fifo.sv
// Power-of-two synchronous FIFO followed by one registered output slot.
// Output valid/data hold while the consumer stalls; level counts FIFO entries only.
module ni_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_in_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [LVL_W-1:0]  o_level
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              w_pop;

  assign o_in_ready  = (r_level < LVL_W'(DEPTH));
  // Refill the slot when it is empty or drains on this edge.
  assign w_pop       = (r_level != '0) && (!r_out_valid || i_out_ready);
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_level     = r_level;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_pop) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_mem[r_rd_ptr];
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ni_param.sv
// GPU <-> leaf-router network interface: rewrites the flit header between
// GPU ID and routing address, buffers each direction, and counts drops.
module ni_param
  import ni_pkg::*;
#(
  parameter int GPU_ID     = 5,
  parameter int DATA_W     = 16,
  parameter int ID_W       = 6,
  parameter int LEAF_W     = 2,
  parameter int MAX_GPU    = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] gpu_data_in,
  input  logic              gpu_valid_in,
  output logic              gpu_ready_out,
  output logic [DATA_W-1:0] gpu_data_out,
  output logic              gpu_valid_out,
  input  logic              gpu_ready_in,
  output logic [DATA_W-1:0] router_data_out,
  output logic              router_valid_out,
  input  logic              router_ready_in,
  input  logic [DATA_W-1:0] router_data_in,
  input  logic              router_valid_in,
  output logic              router_ready_out,
  output logic [CNT_W-1:0]  drop_misroute_cnt,
  output logic [CNT_W-1:0]  drop_baddest_cnt,
  output logic [LVL_W-1:0]  tx_level,
  output logic [LVL_W-1:0]  rx_level
);

  localparam int HDR_LSB = int'(hdr_lsb(DATA_W, ID_W));

  logic [ID_W-1:0]   w_tx_hdr;
  logic [ID_W-1:0]   w_rx_hdr;
  logic [DATA_W-1:0] w_tx_data;
  logic [DATA_W-1:0] w_rx_data;
  logic              w_tx_legal;
  logic              w_rx_match;
  ni_verdict_t       w_tx_v;
  ni_verdict_t       w_rx_v;
  logic [CNT_W-1:0]  r_misroute_cnt;
  logic [CNT_W-1:0]  r_baddest_cnt;

  assign w_tx_hdr   = gpu_data_in[DATA_W-1:HDR_LSB];
  assign w_tx_legal = id_legal(32'(w_tx_hdr), MAX_GPU);
  assign w_tx_data  = {ID_W'(gpu_id_to_addr(32'(w_tx_hdr), LEAF_W)), gpu_data_in[HDR_LSB-1:0]};
  assign w_tx_v     = classify(gpu_valid_in && gpu_ready_out, w_tx_legal);

  // Underflowing headers wrap to huge IDs, so they never match.
  assign w_rx_hdr   = router_data_in[DATA_W-1:HDR_LSB];
  assign w_rx_match = (addr_to_gpu_id(32'(w_rx_hdr), LEAF_W) == 32'(GPU_ID));
  assign w_rx_data  = {ID_W'(GPU_ID), router_data_in[HDR_LSB-1:0]};
  assign w_rx_v     = classify(router_valid_in && router_ready_out, w_rx_match);

  ni_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_tx_v.push),
    .i_data      (w_tx_data),
    .o_in_ready  (gpu_ready_out),
    .o_out_data  (router_data_out),
    .o_out_valid (router_valid_out),
    .i_out_ready (router_ready_in),
    .o_level     (tx_level)
  );

  ni_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_rx_v.push),
    .i_data      (w_rx_data),
    .o_in_ready  (router_ready_out),
    .o_out_data  (gpu_data_out),
    .o_out_valid (gpu_valid_out),
    .i_out_ready (gpu_ready_in),
    .o_level     (rx_level)
  );

  // Drop counters saturate at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_misroute_cnt <= '0;
      r_baddest_cnt  <= '0;
    end else begin
      if (w_rx_v.drop && (r_misroute_cnt != '1)) r_misroute_cnt <= r_misroute_cnt + 1'b1;
      if (w_tx_v.drop && (r_baddest_cnt != '1))  r_baddest_cnt  <= r_baddest_cnt + 1'b1;
    end
  end

  assign drop_misroute_cnt = r_misroute_cnt;
  assign drop_baddest_cnt  = r_baddest_cnt;

endmodule

// File: tb/tb_ni_param.sv
// Self-checking bench for ni_param with default parameters: translation,
// drops, backpressure, wrap-around streaming and reset mid-stream.
module tb_ni_param;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;
  localparam int LVL_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] gpu_data_in;
  logic              gpu_valid_in;
  logic              gpu_ready_out;
  logic [DATA_W-1:0] gpu_data_out;
  logic              gpu_valid_out;
  logic              gpu_ready_in;
  logic [DATA_W-1:0] router_data_out;
  logic              router_valid_out;
  logic              router_ready_in;
  logic [DATA_W-1:0] router_data_in;
  logic              router_valid_in;
  logic              router_ready_out;
  logic [CNT_W-1:0]  drop_misroute_cnt;
  logic [CNT_W-1:0]  drop_baddest_cnt;
  logic [LVL_W-1:0]  tx_level;
  logic [LVL_W-1:0]  rx_level;

  int checks   = 0;
  int failures = 0;
  logic [DATA_W-1:0] tx_q[$];
  logic [DATA_W-1:0] rx_q[$];
  logic [DATA_W-1:0] exp_d;

  ni_param dut (
    .clk(clk), .reset(reset),
    .gpu_data_in(gpu_data_in), .gpu_valid_in(gpu_valid_in), .gpu_ready_out(gpu_ready_out),
    .gpu_data_out(gpu_data_out), .gpu_valid_out(gpu_valid_out), .gpu_ready_in(gpu_ready_in),
    .router_data_out(router_data_out), .router_valid_out(router_valid_out), .router_ready_in(router_ready_in),
    .router_data_in(router_data_in), .router_valid_in(router_valid_in), .router_ready_out(router_ready_out),
    .drop_misroute_cnt(drop_misroute_cnt), .drop_baddest_cnt(drop_baddest_cnt),
    .tx_level(tx_level), .rx_level(rx_level)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Drivers: inputs change 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    gpu_valid_in = 1'b0; gpu_data_in = '0;
    router_valid_in = 1'b0; router_data_in = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; gpu_ready_in = 1'b0; router_ready_in = 1'b0;
    idle_inputs();
    #2;
    checks++; if (router_valid_out !== 1'b0) begin failures++; $display("FAIL rst_router_valid: got %b expected 0", router_valid_out); end
    checks++; if (gpu_valid_out !== 1'b0) begin failures++; $display("FAIL rst_gpu_valid: got %b expected 0", gpu_valid_out); end
    checks++; if (router_data_out !== 16'h0) begin failures++; $display("FAIL rst_router_data: got %h expected 0000", router_data_out); end
    checks++; if (gpu_data_out !== 16'h0) begin failures++; $display("FAIL rst_gpu_data: got %h expected 0000", gpu_data_out); end
    checks++; if (drop_misroute_cnt !== 8'h0 || drop_baddest_cnt !== 8'h0) begin failures++; $display("FAIL rst_counters: got %h/%h expected 00/00", drop_misroute_cnt, drop_baddest_cnt); end
    checks++; if (tx_level !== 4'd0 || rx_level !== 4'd0) begin failures++; $display("FAIL rst_levels: got %0d/%0d expected 0/0", tx_level, rx_level); end
    checks++; if (gpu_ready_out !== 1'b1 || router_ready_out !== 1'b1) begin failures++; $display("FAIL rst_readys: got %b/%b expected 1/1", gpu_ready_out, router_ready_out); end
    step(); step();
    reset = 1'b0;
    step();
    checks++; if (gpu_ready_out !== 1'b1 || router_valid_out !== 1'b0) begin failures++; $display("FAIL post_rst: got ready=%b valid=%b expected 1/0", gpu_ready_out, router_valid_out); end
  endtask

  task automatic test_egress();
    router_ready_in = 1'b1;
    gpu_valid_in = 1'b1; gpu_data_in = 16'h1C05;
    tx_q.push_back(16'h2805);
    step();
    gpu_valid_in = 1'b0;
    checks++; if (router_valid_out !== 1'b0) begin failures++; $display("FAIL egress_lat_k: got valid %b expected 0", router_valid_out); end
    step();
    checks++;
    if (router_valid_out !== 1'b1) begin failures++; $display("FAIL egress_lat_k1: got valid %b expected 1", router_valid_out); end
    else begin
      exp_d = tx_q.pop_front();
      if (router_data_out !== exp_d) begin failures++; $display("FAIL egress_data: got %h expected %h", router_data_out, exp_d); end
    end
    step();
    checks++; if (router_valid_out !== 1'b0) begin failures++; $display("FAIL egress_drain: got valid %b expected 0", router_valid_out); end
  endtask

  task automatic test_ingress();
    gpu_ready_in = 1'b1;
    router_valid_in = 1'b1; router_data_in = 16'h2123;
    rx_q.push_back(16'h1523);
    step();
    router_valid_in = 1'b0;
    step();
    checks++;
    if (gpu_valid_out !== 1'b1) begin failures++; $display("FAIL ingress_valid: got %b expected 1", gpu_valid_out); end
    else begin
      exp_d = rx_q.pop_front();
      if (gpu_data_out !== exp_d) begin failures++; $display("FAIL ingress_data: got %h expected %h", gpu_data_out, exp_d); end
    end
    checks++; if (drop_misroute_cnt !== 8'd0) begin failures++; $display("FAIL ingress_misroute: got %0d expected 0", drop_misroute_cnt); end
    step();
  endtask

  task automatic test_drops();
    router_valid_in = 1'b1; router_data_in = 16'h2523;
    step();
    router_valid_in = 1'b0;
    checks++; if (drop_misroute_cnt !== 8'd1) begin failures++; $display("FAIL misroute_cnt: got %0d expected 1", drop_misroute_cnt); end
    gpu_valid_in = 1'b1; gpu_data_in = 16'h0005;
    step();
    checks++; if (drop_baddest_cnt !== 8'd1) begin failures++; $display("FAIL baddest_cnt_1: got %0d expected 1", drop_baddest_cnt); end
    gpu_data_in = 16'h8400;
    step();
    gpu_valid_in = 1'b0;
    checks++; if (drop_baddest_cnt !== 8'd2) begin failures++; $display("FAIL baddest_cnt_2: got %0d expected 2", drop_baddest_cnt); end
    checks++; if (gpu_ready_out !== 1'b1 || tx_level !== 4'd0) begin failures++; $display("FAIL baddest_ready: got ready=%b level=%0d expected 1/0", gpu_ready_out, tx_level); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (router_valid_out !== 1'b0 || gpu_valid_out !== 1'b0) begin
        failures++; $display("FAIL drop_no_output: got router_valid=%b gpu_valid=%b expected 0/0", router_valid_out, gpu_valid_out);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    logic [DATA_W-1:0] held;
    router_ready_in = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (gpu_ready_out) begin
        gpu_valid_in = 1'b1; gpu_data_in = 16'h0401 + 16'(acc);
        tx_q.push_back(16'h1001 + 16'(acc));
        acc++;
      end else begin
        gpu_valid_in = 1'b0;
      end
      step();
    end
    gpu_valid_in = 1'b0;
    checks++; if (acc != 9) begin failures++; $display("FAIL full_accepted: got %0d expected 9", acc); end
    checks++; if (gpu_ready_out !== 1'b0 || tx_level !== 4'd8) begin failures++; $display("FAIL full_state: got ready=%b level=%0d expected 0/8", gpu_ready_out, tx_level); end
    held = router_data_out;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (router_valid_out !== 1'b1 || router_data_out !== held) begin
        failures++; $display("FAIL stall_stable: got valid=%b data=%h expected 1/%h", router_valid_out, router_data_out, held);
      end
    end
    router_ready_in = 1'b1;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (router_valid_out !== 1'b1 || tx_q.size() == 0) begin
        failures++; $display("FAIL release_valid: got valid=%b at beat %0d expected 1", router_valid_out, i);
      end else begin
        exp_d = tx_q.pop_front();
        if (router_data_out !== exp_d) begin failures++; $display("FAIL release_data: got %h expected %h", router_data_out, exp_d); end
      end
      step();
    end
    checks++; if (router_valid_out !== 1'b0 || tx_level !== 4'd0) begin failures++; $display("FAIL release_empty: got valid=%b level=%0d expected 0/0", router_valid_out, tx_level); end
  endtask

  task automatic test_wrap();
    int tx_sent = 0, rx_sent = 0, cyc = 0, tx_m = 0, rx_m = 0;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic [5:0] id;
    logic [9:0] pay;
    while ((tx_sent < 20 || rx_sent < 20 || tx_q.size() != 0 || rx_q.size() != 0) && cyc < 300) begin
      router_ready_in = (cyc % 2 == 0);
      gpu_ready_in    = (cyc % 2 == 1);
      gpu_valid_in = 1'b0; router_valid_in = 1'b0;
      if (tx_sent < 20 && gpu_ready_out && $urandom_range(0, 3) != 0) begin
        id = 6'($urandom_range(1, 32)); pay = 10'($urandom_range(0, 1023));
        gpu_valid_in = 1'b1; gpu_data_in = {id, pay};
        tx_q.push_back({id + 6'd3, pay});
        tx_sent++;
      end
      if (rx_sent < 20 && router_ready_out && $urandom_range(0, 3) != 0) begin
        pay = 10'($urandom_range(0, 1023));
        router_valid_in = 1'b1; router_data_in = {6'd8, pay};
        rx_q.push_back({6'd5, pay});
        rx_sent++;
      end
      tx_push = gpu_valid_in;
      rx_push = router_valid_in;
      tx_pop  = (tx_m != 0) && (!router_valid_out || router_ready_in);
      rx_pop  = (rx_m != 0) && (!gpu_valid_out || gpu_ready_in);
      if (router_valid_out && router_ready_in) begin
        checks++;
        if (tx_q.size() == 0) begin failures++; $display("FAIL wrap_tx_extra: got %h expected none", router_data_out); end
        else begin
          exp_d = tx_q.pop_front();
          if (router_data_out !== exp_d) begin failures++; $display("FAIL wrap_tx_data: got %h expected %h", router_data_out, exp_d); end
        end
      end
      if (gpu_valid_out && gpu_ready_in) begin
        checks++;
        if (rx_q.size() == 0) begin failures++; $display("FAIL wrap_rx_extra: got %h expected none", gpu_data_out); end
        else begin
          exp_d = rx_q.pop_front();
          if (gpu_data_out !== exp_d) begin failures++; $display("FAIL wrap_rx_data: got %h expected %h", gpu_data_out, exp_d); end
        end
      end
      step();
      tx_m = tx_m + int'(tx_push) - int'(tx_pop);
      rx_m = rx_m + int'(rx_push) - int'(rx_pop);
      checks++;
      if (tx_level !== 4'(tx_m) || rx_level !== 4'(rx_m) || tx_m > 8 || rx_m > 8) begin
        failures++; $display("FAIL wrap_levels: got %0d/%0d expected %0d/%0d", tx_level, rx_level, tx_m, rx_m);
      end
      cyc++;
    end
    idle_inputs();
    checks++; if (cyc >= 300) begin failures++; $display("FAIL wrap_timeout: got %0d pending expected 0", tx_q.size() + rx_q.size()); end
    tx_q.delete(); rx_q.delete();
  endtask

  task automatic test_reset_mid();
    router_ready_in = 1'b0; gpu_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      gpu_valid_in = 1'b1; gpu_data_in = 16'h0C10 + 16'(i);
      step();
    end
    gpu_valid_in = 1'b0;
    step();
    checks++; if (tx_level !== 4'd3 || router_valid_out !== 1'b1) begin failures++; $display("FAIL mid_buffered: got level=%0d valid=%b expected 3/1", tx_level, router_valid_out); end
    reset = 1'b1;
    #1;
    checks++; if (router_valid_out !== 1'b0 || gpu_valid_out !== 1'b0) begin failures++; $display("FAIL mid_rst_valids: got %b/%b expected 0/0", router_valid_out, gpu_valid_out); end
    checks++; if (tx_level !== 4'd0 || rx_level !== 4'd0) begin failures++; $display("FAIL mid_rst_levels: got %0d/%0d expected 0/0", tx_level, rx_level); end
    checks++; if (drop_misroute_cnt !== 8'd0 || drop_baddest_cnt !== 8'd0) begin failures++; $display("FAIL mid_rst_counters: got %0d/%0d expected 0/0", drop_misroute_cnt, drop_baddest_cnt); end
    step(); step();
    reset = 1'b0;
    router_ready_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (router_valid_out !== 1'b0 || tx_level !== 4'd0) begin
        failures++; $display("FAIL mid_stale: got valid=%b level=%0d expected 0/0", router_valid_out, tx_level);
      end
    end
  endtask

  initial begin
    test_reset();
    test_egress();
    test_ingress();
    test_drops();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
